// File: rtl/adder_4bit.sv
// adder_4bit: registered ripple-carry adder with carry-out, signed-overflow
// and zero flags. The result appears one clock after a valid operand pair.
// {cout, sum} is the full (WIDTH+1)-bit unsigned result.

module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Carry chain: carry[i] is the carry into bit i, carry[WIDTH] is cout.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_comb;
    logic             ovf_comb;
    logic             zero_comb;

    // Ripple-carry chain of WIDTH full adders, evaluated combinationally.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        carry    = '0;
        s_comb   = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s_comb[i]    = in1[i] ^ in2[i] ^ carry[i];
            carry[i+1]   = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
        end
    end

    // Signed overflow is the disagreement between the carries into and out
    // of the sign bit; zero looks only at the WIDTH-bit sum, never cout.
    assign ovf_comb  = carry[WIDTH] ^ carry[WIDTH-1];
    assign zero_comb = ~|s_comb;

    // Output register: load on valid, otherwise hold the result and drop
    // out_valid. Reset clears everything, including a result in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= s_comb;
                cout <= carry[WIDTH];
                ovf  <= ovf_comb;
                zero <= zero_comb;
            end
        end
    end

endmodule

// File: tb/tb_adder_4bit.sv
// tb_adder_4bit: self-checking bench for adder_4bit. Expected values come
// from an arithmetic model (integer add plus signed range check).

module tb_adder_4bit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int total = 0;
    int bad   = 0;

    // Packed observation: {out_valid, cout, ovf, zero, sum}
    logic [W+3:0] obs;
    logic [W+3:0] exp_v;
    logic [W+3:0] last_res;
    assign obs = {out_valid, cout, ovf, zero, sum};

    adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer sum and signed-range overflow check.
    function automatic logic [W+3:0] model(input int a, input int b, input int c);
        int u;
        int sa;
        int sb;
        int sr;
        logic co;
        logic ov;
        logic z;
        logic [W-1:0] s;
        u  = a + b + c;
        s  = W'(u % (1 << W));
        co = (u >= (1 << W));
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        sr = sa + sb + c;
        ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        z  = (s == '0);
        return {1'b1, co, ov, z, s};
    endfunction

    // Drive one cycle of inputs at the falling edge, then step to just past
    // the following rising edge, where the registered result is visible.
    task automatic drive(input int a, input int b, input int c, input bit v);
        @(negedge clk);
        in1      = W'(a);
        in2      = W'(b);
        cin      = c[0];
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in1      = 4'hF;
        in2      = 4'hF;
        cin      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got=%h want=%h", i, obs, {(W+4){1'b0}});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_basic();
        int a [5] = '{4, 4, 5, 15, 8};
        int b [5] = '{3, 5, 5, 8, 15};
        for (int i = 0; i < 5; i++) begin
            drive(a[i], b[i], 0, 1'b1);
            exp_v = model(a[i], b[i], 0);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL basic %0d+%0d: got=%b want=%b", a[i], b[i], obs, exp_v);
            end
        end
        // Commutativity: 8+15 must match 15+8.
        total++;
        if (obs !== model(15, 8, 0)) begin
            bad++;
            $display("FAIL commute: got=%b want=%b", obs, model(15, 8, 0));
        end
    endtask

    task automatic test_zero_cin();
        int a [3] = '{8, 15, 0};
        int b [3] = '{8, 0, 0};
        int c [3] = '{0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            drive(a[i], b[i], c[i], 1'b1);
            exp_v = model(a[i], b[i], c[i]);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL zero_cin %0d+%0d+%0d: got=%b want=%b", a[i], b[i], c[i], obs, exp_v);
            end
        end
    endtask

    task automatic test_valid_hold();
        drive(6, 7, 0, 1'b1);
        last_res = model(6, 7, 0);
        total++;
        if (obs !== last_res) begin
            bad++;
            $display("FAIL hold_load: got=%b want=%b", obs, last_res);
        end
        for (int i = 0; i < 2; i++) begin
            drive(9 + i, 3 + i, 1, 1'b0);
            exp_v = {1'b0, last_res[W+2:0]};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL hold_idle cyc%0d: got=%b want=%b", i, obs, exp_v);
            end
        end
        drive(2, 9, 1, 1'b1);
        exp_v = model(2, 9, 1);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL hold_resume: got=%b want=%b", obs, exp_v);
        end
    endtask

    task automatic test_async_reset();
        drive(15, 8, 0, 1'b1);
        exp_v = model(15, 8, 0);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL arst_preload: got=%b want=%b", obs, exp_v);
        end
        // Present a pair, then assert reset between edges.
        @(negedge clk);
        in1      = 4'd3;
        in2      = 4'd3;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL arst_immediate: got=%b want=%b", obs, {(W+4){1'b0}});
        end
        @(posedge clk);
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL arst_held: got=%b want=%b", obs, {(W+4){1'b0}});
        end
        // Release with no valid input: the in-flight 3+3 must never appear.
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL arst_discard: got=%b want=%b", obs, {(W+4){1'b0}});
        end
        // First valid edge after release gives a normal result.
        drive(1, 2, 0, 1'b1);
        exp_v = model(1, 2, 0);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL arst_first: got=%b want=%b", obs, exp_v);
        end
    endtask

    task automatic test_exhaustive();
        int errs;
        errs = 0;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    drive(a, b, c, 1'b1);
                    exp_v = model(a, b, c);
                    total++;
                    if (obs !== exp_v) begin
                        bad++;
                        if (errs < 10)
                            $display("FAIL exhaustive %0d+%0d+%0d: got=%b want=%b", a, b, c, obs, exp_v);
                        errs++;
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        int c;
        bit v;
        drive(0, 1, 0, 1'b1);
        last_res = model(0, 1, 0);
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range((1 << W) - 1, 0));
            b = int'($urandom_range((1 << W) - 1, 0));
            c = int'($urandom_range(1, 0));
            v = ($urandom_range(3, 0) != 0);
            drive(a, b, c, v);
            if (v) last_res = model(a, b, c);
            exp_v = v ? last_res : {1'b0, last_res[W+2:0]};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL random #%0d %0d+%0d+%0d v=%0d: got=%b want=%b", i, a, b, c, v, obs, exp_v);
            end
        end
    endtask

    // Safety net so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        cin      = 1'b0;
        test_reset();
        test_basic();
        test_zero_cin();
        test_valid_hold();
        test_async_reset();
        test_exhaustive();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
